basic_axis_example_control_s_axi: RTL

//   AXI4-Lite control slave upstream of the kernel top. It drives ap_start, mode and axi00_ptr0.
//   It collects ap_done, ap_idle and ap_ready into a host-visible register map and raises an interrupt.
//   It is the host's only control path into the kernel, and runs in the kernel clock domain.

---
 rtl/basic_axis_example_control_s_axi.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/basic_axis_example_control_s_axi.sv
// AXI4-Lite control slave for the basic_axis_example kernel: start/status handshake,
// interrupt enable/status, and the scalar/pointer arguments, all in the ap_clk domain.
module basic_axis_example_control_s_axi #(
   parameter int C_S_AXI_ADDR_WIDTH = 12,
   parameter int C_S_AXI_DATA_WIDTH = 32
) (
   input  logic                            ap_clk,
   input  logic                            ap_rst_n,
   input  logic                            s_axi_control_awvalid,
   output logic                            s_axi_control_awready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
   input  logic                            s_axi_control_wvalid,
   output logic                            s_axi_control_wready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
   output logic                            s_axi_control_bvalid,
   input  logic                            s_axi_control_bready,
   output logic [1:0]                      s_axi_control_bresp,
   input  logic                            s_axi_control_arvalid,
   output logic                            s_axi_control_arready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_araddr,
   output logic                            s_axi_control_rvalid,
   input  logic                            s_axi_control_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_rdata,
   output logic [1:0]                      s_axi_control_rresp,
   output logic                            interrupt,
   output logic                            ap_start,
   input  logic                            ap_done,
   input  logic                            ap_idle,
   input  logic                            ap_ready,
   output logic [31:0]                     mode,
   output logic [63:0]                     axi00_ptr0
);

   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int DW = C_S_AXI_DATA_WIDTH;

   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_GIE    = 4'h1;
   localparam logic [3:0] ADDR_IER    = 4'h2;
   localparam logic [3:0] ADDR_ISR    = 4'h3;
   localparam logic [3:0] ADDR_MODE   = 4'h4;
   localparam logic [3:0] ADDR_PTR_LO = 4'h6;
   localparam logic [3:0] ADDR_PTR_HI = 4'h7;

   typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wstate_t;
   typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rstate_t;

   wstate_t       wstate;
   rstate_t       rstate;
   logic [3:0]    waddr;
   logic          w_hs;
   logic          ar_hs;
   logic [3:0]    raddr;
   logic [DW-1:0] rd_mux;

   logic          done_r;
   logic          ready_r;
   logic          gie;
   logic [1:0]    ier;
   logic [1:0]    isr;
   logic          unused_addr;

   function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old,
                                                input logic [DW-1:0] din,
                                                input logic [DW/8-1:0] strb);
      logic [DW-1:0] res;
      for (int i = 0; i < DW/8; i++)
         res[8*i +: 8] = strb[i] ? din[8*i +: 8] : old[8*i +: 8];
      return res;
   endfunction

   assign w_hs  = s_axi_control_wvalid & s_axi_control_wready;
   assign ar_hs = s_axi_control_arvalid & s_axi_control_arready;
   assign raddr = s_axi_control_araddr[5:2];
   assign s_axi_control_bresp = 2'b00;
   assign s_axi_control_rresp = 2'b00;
   assign unused_addr = ^{s_axi_control_awaddr[AW-1:6], s_axi_control_awaddr[1:0],
                          s_axi_control_araddr[AW-1:6], s_axi_control_araddr[1:0]};

   // Write channel: address, then data, then response; never AW and W together
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wstate                <= WRRESET;
         s_axi_control_awready <= 1'b0;
         s_axi_control_wready  <= 1'b0;
         s_axi_control_bvalid  <= 1'b0;
         waddr                 <= 4'h0;
      end else begin
         case (wstate)
            WRRESET: begin
               wstate                <= WRIDLE;
               s_axi_control_awready <= 1'b1;
            end
            WRIDLE: if (s_axi_control_awvalid) begin
               waddr                 <= s_axi_control_awaddr[5:2];
               s_axi_control_awready <= 1'b0;
               s_axi_control_wready  <= 1'b1;
               wstate                <= WRDATA;
            end
            WRDATA: if (s_axi_control_wvalid) begin
               s_axi_control_wready <= 1'b0;
               s_axi_control_bvalid <= 1'b1;
               wstate               <= WRRESP;
            end
            WRRESP: if (s_axi_control_bready) begin
               s_axi_control_bvalid  <= 1'b0;
               s_axi_control_awready <= 1'b1;
               wstate                <= WRIDLE;
            end
            default: wstate <= WRRESET;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (raddr)
         ADDR_CTRL:   rd_mux = {{(DW-4){1'b0}}, ready_r, ap_idle, done_r, ap_start};
         ADDR_GIE:    rd_mux = {{(DW-1){1'b0}}, gie};
         ADDR_IER:    rd_mux = {{(DW-2){1'b0}}, ier};
         ADDR_ISR:    rd_mux = {{(DW-2){1'b0}}, isr};
         ADDR_MODE:   rd_mux = mode;
         ADDR_PTR_LO: rd_mux = axi00_ptr0[31:0];
         ADDR_PTR_HI: rd_mux = axi00_ptr0[63:32];
         default:     rd_mux = '0;
      endcase
   end

   // Read channel: data captured at the AR handshake and held until taken
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rstate                <= RDRESET;
         s_axi_control_arready <= 1'b0;
         s_axi_control_rvalid  <= 1'b0;
         s_axi_control_rdata   <= '0;
      end else begin
         case (rstate)
            RDRESET: begin
               rstate                <= RDIDLE;
               s_axi_control_arready <= 1'b1;
            end
            RDIDLE: if (s_axi_control_arvalid) begin
               s_axi_control_rdata   <= rd_mux;
               s_axi_control_arready <= 1'b0;
               s_axi_control_rvalid  <= 1'b1;
               rstate                <= RDDATA;
            end
            RDDATA: if (s_axi_control_rready) begin
               s_axi_control_rvalid  <= 1'b0;
               s_axi_control_arready <= 1'b1;
               rstate                <= RDIDLE;
            end
            default: rstate <= RDRESET;
         endcase
      end
   end

   // Register file: kernel events always beat a concurrent host clear or toggle
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ap_start   <= 1'b0;
         done_r     <= 1'b0;
         ready_r    <= 1'b0;
         gie        <= 1'b0;
         ier        <= 2'b00;
         isr        <= 2'b00;
         interrupt  <= 1'b0;
         mode       <= '0;
         axi00_ptr0 <= '0;
      end else begin
         if (w_hs && waddr == ADDR_CTRL && s_axi_control_wstrb[0] && s_axi_control_wdata[0])
            ap_start <= 1'b1;
         else if (ap_ready)
            ap_start <= 1'b0;

         if (ap_done)
            done_r <= 1'b1;
         else if (ar_hs && raddr == ADDR_CTRL)
            done_r <= 1'b0;

         if (ap_ready)
            ready_r <= 1'b1;
         else if (ar_hs && raddr == ADDR_CTRL)
            ready_r <= 1'b0;

         if (w_hs && waddr == ADDR_GIE && s_axi_control_wstrb[0])
            gie <= s_axi_control_wdata[0];
         if (w_hs && waddr == ADDR_IER && s_axi_control_wstrb[0])
            ier <= s_axi_control_wdata[1:0];

         for (int i = 0; i < 2; i++) begin
            if (ier[i] && (i == 0 ? ap_done : ap_ready))
               isr[i] <= 1'b1;
            else if (w_hs && waddr == ADDR_ISR && s_axi_control_wstrb[0] && s_axi_control_wdata[i])
               isr[i] <= ~isr[i];
         end

         interrupt <= gie & (|isr);

         if (w_hs && waddr == ADDR_MODE)
            mode <= apply_strb(mode, s_axi_control_wdata, s_axi_control_wstrb);
         if (w_hs && waddr == ADDR_PTR_LO)
            axi00_ptr0[31:0] <= apply_strb(axi00_ptr0[31:0], s_axi_control_wdata, s_axi_control_wstrb);
         if (w_hs && waddr == ADDR_PTR_HI)
            axi00_ptr0[63:32] <= apply_strb(axi00_ptr0[63:32], s_axi_control_wdata, s_axi_control_wstrb);
      end
   end

endmodule
